uart_prog_loader: RTL

- Serial boot loader on the user-project side of the FPU half-precision SoC.
- Receives the program image as 8N1 UART bytes on mprj_io[5] and assembles them into little-endian 32-bit words.
- Writes each word into the core instruction memory, then releases the core from reset.
- Drives mprj_ready (mprj_io[37]) high once loading completes; downstream the core executes and drives FPU results onto mprj_io[23:8].

---
 rtl/uart_prog_loader_pkg.sv | 23 ++
 rtl/uart_rx_8n1.sv | 102 ++++++++++
 rtl/uart_prog_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
//   rx_state_t : UART receive FSM states
//   ld_state_t : loader FSM states
//   END_WORD   : sentinel word that terminates the image (never written)
//   CLKS_PER_BIT_DEF : default bit period for a 40 MHz clock at 115200 baud
package uart_prog_loader_pkg;

  localparam int          CLKS_PER_BIT_DEF = 347;
  localparam logic [31:0] END_WORD         = 32'h0000_0FFF;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    LD_LOAD,
    LD_DONE
  } ld_state_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop input synchroniser, bit timer and receive FSM.
//   clk, rst_l  : clock, asynchronous active-low reset
//   rx_i        : serial input, idle high
//   hold_idle   : forces the receiver into RX_IDLE (used once loading is done)
//   byte_valid  : one-cycle pulse, byte_data holds a correctly framed byte
//   byte_data   : received byte, LSB first on the wire
//   frame_err   : one-cycle pulse, stop bit was sampled low (byte dropped)
module uart_rx_8n1
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       rx_i,
  input  logic       hold_idle,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state;
  logic             rx_meta;
  logic             rx_sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  assign byte_data = shift;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      // The synchroniser resets to the idle line level so no false start bit
      // is seen as reset releases.
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx_i;
      rx_sync    <= rx_meta;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (hold_idle) begin
        state <= RX_IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          RX_IDLE: begin
            if (!rx_sync) begin
              state <= RX_START;
              cnt   <= '0;
            end
          end
          // Re-check the line half a bit in; a line already back high was a glitch.
          RX_START: begin
            if (cnt == HALF_LAST) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= rx_sync ? RX_IDLE : RX_DATA;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RX_DATA: begin
            if (cnt == BIT_LAST) begin
              cnt     <= '0;
              shift   <= {rx_sync, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= RX_STOP;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RX_STOP: begin
            if (cnt == BIT_LAST) begin
              cnt   <= '0;
              state <= RX_IDLE;
              if (rx_sync) byte_valid <= 1'b1;
              else         frame_err  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial boot loader: assembles UART bytes into little-endian 32-bit words,
// writes them to instruction memory, then releases the core from reset.
//   clk, rst_l    : clock, asynchronous active-low reset
//   rx_i          : UART serial input (idle high)
//   imem_we_o     : one-cycle write strobe
//   imem_addr_o   : word write address
//   imem_wdata_o  : write data
//   core_rst_l_o  : core reset, held low until the image is loaded
//   prog_done_o   : load complete
//   frame_err_o   : sticky, a byte had a low stop bit
//   overflow_o    : sticky, image filled the whole memory
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              rx_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_rst_l_o,
  output logic              prog_done_o,
  output logic              frame_err_o,
  output logic              overflow_o
);

  ld_state_t         ld_state;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ferr;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       word_c;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_l     (rst_l),
    .rx_i      (rx_i),
    .hold_idle (ld_state == LD_DONE),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .frame_err (rx_ferr)
  );

  // The completing byte joins the three buffered ones without a register stage.
  assign word_c = {rx_data, word_buf};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ld_state     <= LD_LOAD;
      byte_cnt     <= '0;
      word_buf     <= '0;
      wr_ptr       <= '0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      core_rst_l_o <= 1'b0;
      prog_done_o  <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      imem_we_o <= 1'b0;
      // A dropped byte leaves byte_cnt alone; the flag is the only trace of it.
      if (rx_ferr) frame_err_o <= 1'b1;

      unique case (ld_state)
        LD_LOAD: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            unique case (byte_cnt)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              2'd3: begin
                if (word_c == END_WORD) begin
                  ld_state <= LD_DONE;
                end else begin
                  imem_we_o    <= 1'b1;
                  imem_addr_o  <= wr_ptr;
                  imem_wdata_o <= word_c;
                  // The last address is written, then loading stops instead of wrapping.
                  if (&wr_ptr) begin
                    overflow_o <= 1'b1;
                    ld_state   <= LD_DONE;
                  end else begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                  end
                end
              end
              default: ;
            endcase
          end
        end
        LD_DONE: begin
          prog_done_o  <= 1'b1;
          core_rst_l_o <= 1'b1;
        end
        default: ld_state <= LD_LOAD;
      endcase
    end
  end

endmodule
